// File: rtl/vx_tex_dcr.sv
// Texture DCR block: per-stage texture state written over the DCR bus and
// read back through a 1-deep registered lookup pipeline.
package vx_tex_pkg;
  localparam int LOD_MAX     = 11;
  localparam int LOD_BITS    = 4;
  localparam int DIM_BITS    = 12;
  localparam int MIPOFF_BITS = 2*DIM_BITS+1;

  typedef struct packed {
    logic [LOD_MAX:0][MIPOFF_BITS-1:0] mipoff;
    logic [1:0][LOD_BITS-1:0]          logdims;
    logic [1:0][1:0]                   wraps;
    logic [31:0]                       baddr;
    logic [2:0]                        format;
    logic                              filter;
  } tex_dcrs_t;
endpackage

module vx_tex_dcr import vx_tex_pkg::*; #(
  parameter logic [11:0] DCR_BASE   = 12'h100,
  parameter int          NUM_STAGES = 2,
  localparam int         SB         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dcr_wr_valid,
  input  logic [11:0]   dcr_wr_addr,
  input  logic [31:0]   dcr_wr_data,
  input  logic          req_valid,
  input  logic [SB-1:0] req_stage,
  output logic          req_ready,
  output logic          rsp_valid,
  output tex_dcrs_t     rsp_dcrs,
  input  logic          rsp_ready
);

  localparam int          MB       = $clog2(LOD_MAX+1);
  localparam logic [11:0] MIP_LAST = 12'(6 + LOD_MAX);

  tex_dcrs_t       stages [NUM_STAGES];
  logic [SB-1:0]   wsel;
  logic            wsel_bad;
  logic [11:0]     offset;
  logic [MB-1:0]   mip_idx;
  logic            stage_ok;

  // Addresses below DCR_BASE wrap to large offsets and fall out of range.
  assign offset   = dcr_wr_addr - DCR_BASE;
  assign mip_idx  = MB'(offset - 12'd6);
  assign stage_ok = 32'(req_stage) < 32'(NUM_STAGES);
  assign req_ready = !rsp_valid || rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++) stages[i] <= '0;
      wsel     <= '0;
      wsel_bad <= 1'b0;
    end else if (dcr_wr_valid) begin
      if (offset == 12'd0) begin
        wsel     <= dcr_wr_data[SB-1:0];
        wsel_bad <= dcr_wr_data >= 32'(NUM_STAGES);
      end else if (!wsel_bad) begin
        case (offset)
          12'd1: stages[wsel].baddr <= dcr_wr_data;
          12'd2: begin
            stages[wsel].logdims[0] <= dcr_wr_data[LOD_BITS-1:0];
            stages[wsel].logdims[1] <= dcr_wr_data[16 +: LOD_BITS];
          end
          12'd3: stages[wsel].format <= dcr_wr_data[2:0];
          12'd4: stages[wsel].filter <= dcr_wr_data[0];
          12'd5: begin
            stages[wsel].wraps[0] <= dcr_wr_data[1:0];
            stages[wsel].wraps[1] <= dcr_wr_data[17:16];
          end
          default: begin
            if (offset >= 12'd6 && offset <= MIP_LAST)
              stages[wsel].mipoff[mip_idx] <= dcr_wr_data[MIPOFF_BITS-1:0];
          end
        endcase
      end
    end
  end

  // Lookup reads the pre-write register value, so same-cycle writes show next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_dcrs  <= '0;
    end else if (req_valid && req_ready) begin
      rsp_valid <= 1'b1;
      rsp_dcrs  <= stage_ok ? stages[req_stage] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_tex_dcr.sv
// Directed bench for vx_tex_dcr: DCR field decode, stage selection, lookup
// pipeline backpressure and async reset behaviour.
module tb_vx_tex_dcr;
  import vx_tex_pkg::*;

  localparam logic [11:0] BASE = 12'h100;

  logic        clk;
  logic        reset;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic        req_valid;
  logic        req_stage;
  logic [1:0]  req_stage3;
  logic        req_ready, req_ready3;
  logic        rsp_valid, rsp_valid3;
  tex_dcrs_t   rsp_dcrs, rsp_dcrs3;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;

  int          s_stage [7] = '{0, 1, 0, 1, 1, 0, 0};
  logic        s_rdy   [7] = '{1, 1, 1, 0, 1, 1, 1};
  logic        s_req   [7] = '{1, 1, 1, 1, 1, 1, 0};
  logic        s_rr    [7] = '{1, 1, 1, 0, 1, 1, 1};
  logic        s_vld   [7] = '{1, 1, 1, 1, 1, 1, 0};
  logic [31:0] s_baddr [7] = '{32'h1111, 32'hDEADBEEF, 32'h1111, 32'h1111,
                               32'hDEADBEEF, 32'h2222, 32'h2222};

  vx_tex_dcr #(.DCR_BASE(BASE), .NUM_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .req_valid(req_valid), .req_stage(req_stage), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_dcrs(rsp_dcrs), .rsp_ready(rsp_ready)
  );

  // Three-stage instance so an out-of-range stage index is representable.
  vx_tex_dcr #(.DCR_BASE(BASE), .NUM_STAGES(3)) dut3 (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .req_valid(req_valid), .req_stage(req_stage3), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_dcrs(rsp_dcrs3), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = addr;
    dcr_wr_data  = data;
    @(posedge clk); #1;
    dcr_wr_valid = 1'b0;
  endtask

  task automatic lookup(input logic stage);
    req_valid = 1'b1;
    req_stage = stage;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; dcr_wr_valid = 1'b0; dcr_wr_addr = '0; dcr_wr_data = '0;
    req_valid = 1'b0; req_stage = 1'b0; req_stage3 = 2'd0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_dcrs_zero", rsp_dcrs == '0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;

    wr(BASE + 12'd0, 32'd1);
    wr(BASE + 12'd1, 32'hDEADBEEF);
    lookup(1'b1);
    chk("lk1_valid", rsp_valid, 1'b1);
    chk("lk1_baddr", rsp_dcrs.baddr, 32'hDEADBEEF);
    lookup(1'b0);
    chk("lk0_baddr", rsp_dcrs.baddr, 32'h0);
    @(posedge clk); #1;
    chk("rsp_clears", rsp_valid, 1'b0);

    wr(BASE + 12'd2, 32'h0009_0008);
    wr(BASE + 12'd5, 32'h0002_0001);
    wr(BASE + 12'd3, 32'h0000_000D);
    wr(BASE + 12'd4, 32'h0000_0003);
    lookup(1'b1);
    chk("logdim_u", rsp_dcrs.logdims[0], 4'd8);
    chk("logdim_v", rsp_dcrs.logdims[1], 4'd9);
    chk("wrap_u", rsp_dcrs.wraps[0], 2'd1);
    chk("wrap_v", rsp_dcrs.wraps[1], 2'd2);
    chk("format", rsp_dcrs.format, 3'd5);
    chk("filter", rsp_dcrs.filter, 1'b1);

    wr(BASE + 12'd17, 32'hFFFF_FFFF);
    wr(BASE + 12'd6, 32'h0000_0123);
    wr(BASE + 12'd18, 32'h0000_AAAA);
    wr(BASE - 12'd1, 32'h0000_BBBB);
    lookup(1'b1);
    chk("mipoff11", rsp_dcrs.mipoff[11], 25'h1FFFFFF);
    chk("mipoff0", rsp_dcrs.mipoff[0], 25'h123);
    chk("oob_baddr", rsp_dcrs.baddr, 32'hDEADBEEF);

    wr(BASE + 12'd0, 32'd0);
    wr(BASE + 12'd1, 32'h1111);
    lookup(1'b0);
    chk("st0_baddr", rsp_dcrs.baddr, 32'h1111);
    chk("st0_isolated", rsp_dcrs.logdims[0], 4'd0);

    // Streaming lookups with a one-cycle consumer stall and a write to the held stage.
    for (int c = 0; c < 7; c++) begin
      req_valid = s_req[c];
      req_stage = s_stage[c][0];
      rsp_ready = s_rdy[c];
      dcr_wr_valid = (c == 3);
      dcr_wr_addr  = BASE + 12'd1;
      dcr_wr_data  = 32'h2222;
      #1;
      chk($sformatf("strm_ready_%0d", c), req_ready, s_rr[c]);
      @(posedge clk); #1;
      chk($sformatf("strm_valid_%0d", c), rsp_valid, s_vld[c]);
      if (c < 6) chk($sformatf("strm_baddr_%0d", c), rsp_dcrs.baddr, s_baddr[c]);
    end
    req_valid = 1'b0; dcr_wr_valid = 1'b0; rsp_ready = 1'b1;

    wr(BASE + 12'd0, 32'd5);
    wr(BASE + 12'd1, 32'h55);
    lookup(1'b0);
    chk("bad_sel_st0", rsp_dcrs.baddr, 32'h2222);
    req_stage3 = 2'd3;
    lookup(1'b1);
    req_stage3 = 2'd0;
    chk("bad_sel_st1", rsp_dcrs.baddr, 32'hDEADBEEF);
    chk("oor_valid", rsp_valid3, 1'b1);
    chk("oor_zero", rsp_dcrs3 == '0, 1'b1);
    wr(BASE + 12'd0, 32'd1);
    wr(BASE + 12'd1, 32'h77);
    lookup(1'b1);
    chk("resel_baddr", rsp_dcrs.baddr, 32'h77);

    rsp_ready = 1'b0;
    lookup(1'b1);
    chk("pre_rst_valid", rsp_valid, 1'b1);
    chk("pre_rst_mip11", rsp_dcrs.mipoff[11], 25'h1FFFFFF);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_dcrs", rsp_dcrs == '0, 1'b1);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    lookup(1'b1);
    chk("post_rst_mip11", rsp_dcrs.mipoff[11], 25'h0);
    chk("post_rst_baddr", rsp_dcrs.baddr, 32'h0);

    dcr_wr_valid = 1'b1; dcr_wr_addr = BASE + 12'd1; dcr_wr_data = 32'h10;
    req_valid = 1'b1; req_stage = 1'b0;
    @(posedge clk); #1;
    dcr_wr_valid = 1'b0; req_valid = 1'b0;
    chk("same_cyc_old", rsp_dcrs.baddr, 32'h0);
    lookup(1'b0);
    chk("same_cyc_new", rsp_dcrs.baddr, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
